// File: rtl/tx_mixer_nco.sv
// Quadrature TX upconverter: tx_channel = I*cos - Q*sin, with fs/4, NCO, bypass and mute carriers.
// Define TX_MIXER_SAT_EN to saturate on overflow; by default results wrap to DATA_W.
module tx_mixer_nco #(
    parameter int DATA_W     = 18,
    parameter int COEF_W     = 18,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 8,
    parameter     LUT_FILE   = "cos_lut.hex"
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               phase_clr,
    input  logic [DATA_W-1:0]  tx_inph,
    input  logic [DATA_W-1:0]  tx_quad,
    output logic [DATA_W-1:0]  tx_channel,
    output logic               out_valid,
    output logic [PHASE_W-1:0] phase_out
);

    localparam logic [1:0] MODE_BYP  = 2'b00;
    localparam logic [1:0] MODE_FS4  = 2'b01;
    localparam logic [1:0] MODE_NCO  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    localparam int LUT_N = 1 << LUT_ADDR_W;
    localparam int QTR   = LUT_N / 4;
    localparam int PW    = DATA_W + COEF_W;
    localparam int DW    = PW + 1;
    localparam int XW    = DATA_W + 2;

    localparam logic [LUT_ADDR_W-1:0] QTR_A = LUT_ADDR_W'(QTR);
    localparam logic signed [DW-1:0]  RND   = DW'(1) <<< (COEF_W - 2);
    localparam logic signed [XW-1:0]  SAT_HI = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0]  SAT_LO = {3'b111, {(DATA_W-1){1'b0}}};

    localparam longint TWO30      = 64'sd1073741824;
    localparam longint TWO_PI_Q30 = 64'sd6746518852;
    localparam longint COEF_MAX   = (longint'(1) << (COEF_W - 1)) - 1;

    // First-quadrant cosine by Taylor series in Q30; m == QTR is exactly zero.
    function automatic longint quarter_cos(input int m);
        longint x, x2, term, sum;
        if (m >= QTR) return 0;
        x    = (longint'(m) * TWO_PI_Q30) / LUT_N;
        x2   = (x * x) / TWO30;
        term = TWO30;
        sum  = TWO30;
        for (int n = 1; n <= 8; n++) begin
            term = -(term * x2) / (TWO30 * (2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return (sum * COEF_MAX + TWO30 / 2) / TWO30;
    endfunction

    function automatic logic signed [COEF_W-1:0] cos_entry(input int idx);
        longint v;
        case (idx / QTR)
            0:       v = quarter_cos(idx % QTR);
            1:       v = -quarter_cos(QTR - idx % QTR);
            2:       v = -quarter_cos(idx % QTR);
            default: v = quarter_cos(QTR - idx % QTR);
        endcase
        return v[COEF_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] fit(input logic signed [XW-1:0] x);
`ifdef TX_MIXER_SAT_EN
        if (x > SAT_HI)      return SAT_HI[DATA_W-1:0];
        else if (x < SAT_LO) return SAT_LO[DATA_W-1:0];
        else                 return x[DATA_W-1:0];
`else
        return x[DATA_W-1:0];
`endif
    endfunction

    // Cosine table built at elaboration; sine reads it a quarter turn back.
    logic signed [COEF_W-1:0] rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam logic signed [COEF_W-1:0] ENTRY = cos_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [PHASE_W-1:0]       acc_q, acc_d;
    logic [1:0]               p_q, p_d;
    logic signed [DATA_W-1:0] i1_q, i1_d, q1_q, q1_d;
    logic [1:0]               mode1_q, mode1_d, p1_q, p1_d;
    logic [LUT_ADDR_W-1:0]    addr1_q, addr1_d;
    logic signed [DATA_W-1:0] i2_q, i2_d, q2_q, q2_d;
    logic [1:0]               mode2_q, mode2_d, p2_q, p2_d;
    logic signed [COEF_W-1:0] cos2_q, cos2_d, sin2_q, sin2_d;
    logic signed [PW-1:0]     pi3_q, pi3_d, pq3_q, pq3_d;
    logic signed [DATA_W:0]   dir3_q, dir3_d;
    logic [1:0]               mode3_q, mode3_d;
    logic [DATA_W-1:0]        tx_q, tx_d;
    logic [2:0]               vld_q, vld_d;
    logic                     out_valid_q, out_valid_d;

    logic [LUT_ADDR_W-1:0]    addr_s;
    logic [1:0]               p_s;
    logic signed [DATA_W:0]   ie_s, qe_s, dir_s;
    logic signed [DW-1:0]     diff_s;
    logic signed [XW-1:0]     nco_s, out_s;

    always_comb begin
        ie_s  = (DATA_W+1)'(i2_q);
        qe_s  = (DATA_W+1)'(q2_q);
        dir_s = '0;
        case (mode2_q)
            MODE_BYP: dir_s = ie_s;
            MODE_FS4: begin
                case (p2_q)
                    2'd0:    dir_s = ie_s;
                    2'd1:    dir_s = -qe_s;
                    2'd2:    dir_s = -ie_s;
                    default: dir_s = qe_s;
                endcase
            end
            MODE_NCO, MODE_MUTE: dir_s = '0;
            default:             dir_s = '0;
        endcase
    end

    always_comb begin
        diff_s = DW'(pi3_q) - DW'(pq3_q);
        nco_s  = XW'((diff_s + RND) >>> (COEF_W - 1));
        out_s  = (mode3_q == MODE_NCO) ? nco_s : XW'(dir3_q);
    end

    always_comb begin
        addr_s      = phase_clr ? '0 : acc_q[PHASE_W-1 -: LUT_ADDR_W];
        p_s         = phase_clr ? 2'd0 : p_q;
        acc_d       = acc_q;
        p_d         = p_q;
        i1_d        = i1_q;
        q1_d        = q1_q;
        mode1_d     = mode1_q;
        addr1_d     = addr1_q;
        p1_d        = p1_q;
        i2_d        = i2_q;
        q2_d        = q2_q;
        mode2_d     = mode2_q;
        p2_d        = p2_q;
        cos2_d      = cos2_q;
        sin2_d      = sin2_q;
        pi3_d       = pi3_q;
        pq3_d       = pq3_q;
        dir3_d      = dir3_q;
        mode3_d     = mode3_q;
        tx_d        = tx_q;
        vld_d       = vld_q;
        if (clk_en) begin
            acc_d   = phase_clr ? freq_word : acc_q + freq_word;
            p_d     = p_s + 2'd1;
            i1_d    = tx_inph;
            q1_d    = tx_quad;
            mode1_d = mode;
            addr1_d = addr_s;
            p1_d    = p_s;
            i2_d    = i1_q;
            q2_d    = q1_q;
            mode2_d = mode1_q;
            p2_d    = p1_q;
            cos2_d  = rom[addr1_q];
            sin2_d  = rom[addr1_q - QTR_A];
            pi3_d   = PW'(i2_q) * PW'(cos2_q);
            pq3_d   = PW'(q2_q) * PW'(sin2_q);
            dir3_d  = dir_s;
            mode3_d = mode2_q;
            tx_d    = fit(out_s);
            vld_d   = {vld_q[1:0], 1'b1};
        end
        out_valid_d = clk_en & vld_q[2];
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            p_q         <= '0;
            i1_q        <= '0;
            q1_q        <= '0;
            mode1_q     <= '0;
            addr1_q     <= '0;
            p1_q        <= '0;
            i2_q        <= '0;
            q2_q        <= '0;
            mode2_q     <= '0;
            p2_q        <= '0;
            cos2_q      <= '0;
            sin2_q      <= '0;
            pi3_q       <= '0;
            pq3_q       <= '0;
            dir3_q      <= '0;
            mode3_q     <= '0;
            tx_q        <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            p_q         <= p_d;
            i1_q        <= i1_d;
            q1_q        <= q1_d;
            mode1_q     <= mode1_d;
            addr1_q     <= addr1_d;
            p1_q        <= p1_d;
            i2_q        <= i2_d;
            q2_q        <= q2_d;
            mode2_q     <= mode2_d;
            p2_q        <= p2_d;
            cos2_q      <= cos2_d;
            sin2_q      <= sin2_d;
            pi3_q       <= pi3_d;
            pq3_q       <= pq3_d;
            dir3_q      <= dir3_d;
            mode3_q     <= mode3_d;
            tx_q        <= tx_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign tx_channel = tx_q;
    assign out_valid  = out_valid_q;
    assign phase_out  = acc_q;

endmodule

// File: tb/tb_tx_mixer_nco.sv
// Directed vector bench for tx_mixer_nco: fs/4, NCO, bypass, mute, clk_en gating and async reset.
// Expected values are hand-derived; the saturation corner follows TX_MIXER_SAT_EN.
module tb_tx_mixer_nco;

`ifdef TX_MIXER_SAT_EN
    localparam int SAT_NEG = 131071;
`else
    localparam int SAT_NEG = -131072;
`endif

    typedef struct {
        bit          rst;
        bit          en;
        logic [1:0]  md;
        logic [15:0] fw;
        bit          clr;
        int          i;
        int          q;
        int          tx;
        bit          vld;
        int          ph;
    } vec_t;

    logic               sys_clk;
    logic               reset;
    logic               clk_en;
    logic [1:0]         mode;
    logic [15:0]        freq_word;
    logic               phase_clr;
    logic signed [17:0] tx_inph;
    logic signed [17:0] tx_quad;
    logic signed [17:0] tx_channel;
    logic               out_valid;
    logic [15:0]        phase_out;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    tx_mixer_nco dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .mode       (mode),
        .freq_word  (freq_word),
        .phase_clr  (phase_clr),
        .tx_inph    (tx_inph),
        .tx_quad    (tx_quad),
        .tx_channel (tx_channel),
        .out_valid  (out_valid),
        .phase_out  (phase_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want summary before 100us");
        $fatal(1);
    end

    task automatic add(input int rst, input int en, input int md, input int fw,
                       input int clr, input int i, input int q,
                       input int tx, input int vld, input int ph);
        vec_t v;
        v.rst = rst[0];
        v.en  = en[0];
        v.md  = 2'(md);
        v.fw  = 16'(fw);
        v.clr = clr[0];
        v.i   = i;
        v.q   = q;
        v.tx  = tx;
        v.vld = vld[0];
        v.ph  = ph;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d, want %0d",
                     nm, idx, $signed(act), $signed(exp));
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        clk_en    = 1'b0;
        mode      = 2'b00;
        freq_word = '0;
        phase_clr = 1'b0;
        tx_inph   = '0;
        tx_quad   = '0;

        // fs/4 with I=16384, then I=-131072 for the negation corner (p=2)
        //  rst en md fw     clr i        q      tx       vld ph
        add(1, 1, 1, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     -16384,  1, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 1, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     0,       1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     -16384,  1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     0,       1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     -131072, 1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     0,       1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     SAT_NEG, 1, 0);
        add(0, 1, 1, 0,     0, -131072, 0,     0,       1, 0);

        // NCO at fs/4 step: I-only then Q-only through 0/90/180/270 degrees
        add(1, 1, 2, 16384, 1, 16384,   0,     0,       0, 16384);
        add(0, 1, 2, 16384, 0, 16384,   0,     0,       0, 32768);
        add(0, 1, 2, 16384, 0, 16384,   0,     0,       0, 49152);
        add(0, 1, 2, 16384, 0, 16384,   0,     16384,   1, 0);
        add(0, 1, 2, 16384, 0, 0,       16384, 0,       1, 16384);
        add(0, 1, 2, 16384, 0, 0,       16384, -16384,  1, 32768);
        add(0, 1, 2, 16384, 0, 0,       16384, 0,       1, 49152);
        add(0, 1, 2, 16384, 0, 0,       16384, 0,       1, 0);
        add(0, 1, 2, 16384, 0, 0,       0,     -16384,  1, 16384);
        add(0, 1, 2, 16384, 0, 0,       0,     0,       1, 32768);
        add(0, 1, 2, 16384, 0, 0,       0,     16384,   1, 49152);

        // clk_en toggling; clr/fw on disabled cycles must be ignored; 65535 wraps to 0
        add(1, 1, 2, 65535, 1, 16384,   0,     0,       0, 65535);
        add(0, 0, 2, 1,     0, 0,       0,     0,       0, 65535);
        add(0, 1, 2, 1,     0, 0,       0,     0,       0, 0);
        add(0, 0, 2, 16384, 1, 0,       0,     0,       0, 0);
        add(0, 1, 2, 16384, 0, 16384,   0,     0,       0, 16384);
        add(0, 0, 2, 16384, 0, 16384,   0,     0,       0, 16384);
        add(0, 1, 2, 16384, 0, 16384,   0,     16384,   1, 32768);
        add(0, 0, 2, 16384, 0, 16384,   0,     16384,   0, 32768);
        add(0, 1, 2, 16384, 0, 16384,   0,     0,       1, 49152);
        add(0, 0, 2, 16384, 0, 16384,   0,     0,       0, 49152);
        add(0, 1, 2, 16384, 0, 16384,   0,     16384,   1, 0);
        add(0, 0, 2, 16384, 0, 16384,   0,     16384,   0, 0);

        // NCO -> mute -> NCO, then reset mid-stream
        add(1, 1, 2, 0,     1, 16384,   0,     0,       0, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 3, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 3, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 3, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 3, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       1, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     16384,   1, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     16384,   1, 0);
        add(1, 1, 2, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     0,       0, 0);
        add(0, 1, 2, 0,     0, 16384,   0,     16384,   1, 0);

        // bypass: Q ignored
        add(1, 1, 0, 0,     0, -5000,   7000,  0,       0, 0);
        add(0, 1, 0, 0,     0, -5000,   7000,  0,       0, 0);
        add(0, 1, 0, 0,     0, -5000,   7000,  0,       0, 0);
        add(0, 1, 0, 0,     0, -5000,   7000,  -5000,   1, 0);
        add(0, 1, 0, 0,     0, -5000,   7000,  -5000,   1, 0);

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            if (v.rst) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_tx", k, 32'(tx_channel), 32'd0);
                chk("rst_vld", k, {31'd0, out_valid}, 32'd0);
                chk("rst_ph", k, {16'd0, phase_out}, 32'd0);
                reset = 1'b0;
            end
            clk_en    = v.en;
            mode      = v.md;
            freq_word = v.fw;
            phase_clr = v.clr;
            tx_inph   = 18'(v.i);
            tx_quad   = 18'(v.q);
            @(posedge sys_clk);
            #1;
            chk("tx", k, 32'(tx_channel), v.tx);
            chk("vld", k, {31'd0, out_valid}, {31'd0, v.vld});
            chk("ph", k, {16'd0, phase_out}, v.ph);
        end

        // long clk_en=0 stretch with changed inputs: everything holds, no valid
        clk_en  = 1'b0;
        mode    = 2'b11;
        tx_inph = 18'sd1234;
        for (int c = 0; c < 5; c++) begin
            @(posedge sys_clk);
            #1;
            chk("hold_tx", c, 32'(tx_channel), -5000);
            chk("hold_vld", c, {31'd0, out_valid}, 32'd0);
        end
        clk_en = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("resume_tx", 0, 32'(tx_channel), -5000);
        chk("resume_vld", 0, {31'd0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
